// File: rtl/wired_lsu_sb.sv
// Load/store unit store buffer: circular FIFO of pending stores whose per-way
// dcache hit vectors track tag writes, plus a word-granular load conflict query.
module wired_lsu_sb #(
    parameter int DEPTH   = 4,
    parameter int WAYS    = 4,
    parameter int PADDR_W = 32,
    parameter int IDX_LO  = 4,
    parameter int IDX_HI  = 11
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push_valid_i,
    output logic                          push_ready_o,
    input  logic [PADDR_W-1:0]            push_paddr_i,
    input  logic [31:0]                   push_wdata_i,
    input  logic [3:0]                    push_wstrb_i,
    input  logic [WAYS-1:0]               push_hit_i,
    input  logic                          pop_i,
    output logic                          head_valid_o,
    output logic [PADDR_W-1:0]            head_paddr_o,
    output logic [31:0]                   head_wdata_o,
    output logic [3:0]                    head_wstrb_o,
    output logic [WAYS-1:0]               head_hit_o,
    input  logic [PADDR_W-1:0]            snoop_taddr_i,
    input  logic [WAYS-1:0]               snoop_twe_i,
    input  logic [PADDR_W-IDX_HI-2:0]     snoop_tag_i,
    input  logic                          snoop_wp_i,
    input  logic [PADDR_W-1:0]            q_paddr_i,
    output logic                          q_conflict_o,
    input  logic                          clear_i,
    output logic [$clog2(DEPTH):0]        count_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d, count;
    logic [IDX_W-1:0]   head_idx, tail_idx;
    logic [DEPTH-1:0]   valid;
    logic               push_fire, pop_fire;

    logic [PADDR_W-1:0] paddr_q [DEPTH];
    logic [31:0]        wdata_q [DEPTH];
    logic [3:0]         wstrb_q [DEPTH];
    logic [WAYS-1:0]    hit_q   [DEPTH];
    logic [WAYS-1:0]    hit_d   [DEPTH];

    logic               unused_bits;
    assign unused_bits = ^{snoop_taddr_i[PADDR_W-1:IDX_HI+1], snoop_taddr_i[IDX_LO-1:0],
                           q_paddr_i[1:0]};

    // A tag write to the same set re-evaluates the hit bit of every written way.
    function automatic logic [WAYS-1:0] snoop(input logic [PADDR_W-1:0] pa,
                                              input logic [WAYS-1:0]    h);
        logic [WAYS-1:0] r;
        r = h;
        if (pa[IDX_HI:IDX_LO] == snoop_taddr_i[IDX_HI:IDX_LO]) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                if (snoop_twe_i[w]) begin
                    r[w] = (snoop_tag_i == pa[PADDR_W-1:IDX_HI+1]) && snoop_wp_i;
                end
            end
        end
        return r;
    endfunction

    assign count        = tail_q - head_q;
    assign head_idx     = head_q[IDX_W-1:0];
    assign tail_idx     = tail_q[IDX_W-1:0];
    assign push_ready_o = (count != PTR_W'(DEPTH));
    assign head_valid_o = (count != '0);
    assign count_o      = count;
    assign push_fire    = push_valid_i && push_ready_o && !clear_i;
    assign pop_fire     = pop_i && head_valid_o && !clear_i;

    assign head_paddr_o = head_valid_o ? paddr_q[head_idx] : '0;
    assign head_wdata_o = head_valid_o ? wdata_q[head_idx] : '0;
    assign head_wstrb_o = head_valid_o ? wstrb_q[head_idx] : '0;
    assign head_hit_o   = head_valid_o ? hit_q[head_idx]   : '0;

    always_comb begin
        head_d = clear_i ? '0 : head_q + PTR_W'(pop_fire);
        tail_d = clear_i ? '0 : tail_q + PTR_W'(push_fire);
    end

    // Entry i is live when its distance from the head is below the occupancy.
    always_comb begin
        valid        = '0;
        q_conflict_o = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            valid[i] = ({1'b0, IDX_W'(i) - head_idx} < count);
            if (valid[i] && (paddr_q[i][PADDR_W-1:2] == q_paddr_i[PADDR_W-1:2])) begin
                q_conflict_o = 1'b1;
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            hit_d[i] = valid[i] ? snoop(paddr_q[i], hit_q[i]) : hit_q[i];
            if (push_fire && (IDX_W'(i) == tail_idx)) begin
                hit_d[i] = snoop(push_paddr_i, push_hit_i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            hit_q[i] <= hit_d[i];
        end
        if (push_fire) begin
            paddr_q[tail_idx] <= push_paddr_i;
            wdata_q[tail_idx] <= push_wdata_i;
            wstrb_q[tail_idx] <= push_wstrb_i;
        end
    end

endmodule

// File: tb/tb_wired_lsu_sb.sv
// Directed bench for wired_lsu_sb: scoreboard queue of expected entries,
// updated by a reference snoop rule, compared whenever the head retires.
module tb_wired_lsu_sb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        push_valid_i = 1'b0;
    logic        push_ready_o;
    logic [31:0] push_paddr_i = '0;
    logic [31:0] push_wdata_i = '0;
    logic [3:0]  push_wstrb_i = '0;
    logic [3:0]  push_hit_i = '0;
    logic        pop_i = 1'b0;
    logic        head_valid_o;
    logic [31:0] head_paddr_o;
    logic [31:0] head_wdata_o;
    logic [3:0]  head_wstrb_o;
    logic [3:0]  head_hit_o;
    logic [31:0] snoop_taddr_i = '0;
    logic [3:0]  snoop_twe_i = '0;
    logic [19:0] snoop_tag_i = '0;
    logic        snoop_wp_i = 1'b0;
    logic [31:0] q_paddr_i = '0;
    logic        q_conflict_o;
    logic        clear_i = 1'b0;
    logic [2:0]  count_o;

    wired_lsu_sb #(.DEPTH(4), .WAYS(4), .PADDR_W(32), .IDX_LO(4), .IDX_HI(11)) dut (
        .clk(clk), .rst_n(rst_n),
        .push_valid_i(push_valid_i), .push_ready_o(push_ready_o),
        .push_paddr_i(push_paddr_i), .push_wdata_i(push_wdata_i),
        .push_wstrb_i(push_wstrb_i), .push_hit_i(push_hit_i),
        .pop_i(pop_i), .head_valid_o(head_valid_o),
        .head_paddr_o(head_paddr_o), .head_wdata_o(head_wdata_o),
        .head_wstrb_o(head_wstrb_o), .head_hit_o(head_hit_o),
        .snoop_taddr_i(snoop_taddr_i), .snoop_twe_i(snoop_twe_i),
        .snoop_tag_i(snoop_tag_i), .snoop_wp_i(snoop_wp_i),
        .q_paddr_i(q_paddr_i), .q_conflict_o(q_conflict_o),
        .clear_i(clear_i), .count_o(count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] paddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [3:0]  hit;
    } ent_t;

    ent_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] ref_snoop(input logic [31:0] pa, input logic [3:0] h);
        logic [3:0] r;
        r = h;
        if (pa[11:4] == snoop_taddr_i[11:4]) begin
            for (int w = 0; w < 4; w++) begin
                if (snoop_twe_i[w]) r[w] = (snoop_tag_i == pa[31:12]) && snoop_wp_i;
            end
        end
        return r;
    endfunction

    function automatic logic ref_conflict(input logic [31:0] qa);
        logic c;
        c = 1'b0;
        foreach (sb[i]) if (sb[i].paddr[31:2] == qa[31:2]) c = 1'b1;
        return c;
    endfunction

    // One clock: model update from the current inputs, then post-edge checks.
    task automatic tick();
        ent_t e;
        bit   do_pop, do_push;
        do_pop  = pop_i && (sb.size() > 0);
        do_push = push_valid_i && (sb.size() < 4);
        if (clear_i) begin
            sb.delete();
        end else begin
            if (do_pop) begin
                check("pop_paddr", head_paddr_o, sb[0].paddr);
                check("pop_wdata", head_wdata_o, sb[0].wdata);
                check("pop_wstrb", head_wstrb_o, sb[0].wstrb);
                check("pop_hit",   head_hit_o,   sb[0].hit);
                void'(sb.pop_front());
            end
            foreach (sb[i]) begin
                e = sb[i];
                e.hit = ref_snoop(e.paddr, e.hit);
                sb[i] = e;
            end
            if (do_push) begin
                e.paddr = push_paddr_i;
                e.wdata = push_wdata_i;
                e.wstrb = push_wstrb_i;
                e.hit   = ref_snoop(push_paddr_i, push_hit_i);
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        check("count", count_o, sb.size());
        check("push_ready", push_ready_o, sb.size() < 4);
        check("head_valid", head_valid_o, sb.size() > 0);
        if (sb.size() > 0) begin
            check("head_paddr", head_paddr_o, sb[0].paddr);
            check("head_hit", head_hit_o, sb[0].hit);
        end else begin
            check("head_paddr_empty", head_paddr_o, 0);
        end
    endtask

    task automatic set_push(input logic [31:0] pa, input logic [3:0] h);
        push_valid_i = 1'b1;
        push_paddr_i = pa;
        push_wdata_i = pa ^ 32'hA5A5_0000;
        push_wstrb_i = pa[7:4] | 4'b0001;
        push_hit_i   = h;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_count"}, count_o, 0);
        check({tag, "_head_valid"}, head_valid_o, 0);
        check({tag, "_head_paddr"}, head_paddr_o, 0);
        check({tag, "_head_wdata"}, head_wdata_o, 0);
        check({tag, "_head_wstrb"}, head_wstrb_o, 0);
        check({tag, "_head_hit"}, head_hit_o, 0);
        check({tag, "_push_ready"}, push_ready_o, 1);
        check({tag, "_q_conflict"}, q_conflict_o, 0);
    endtask

    initial begin
        @(posedge clk);
        #1;
        check_reset_outputs("reset");
        #2 rst_n = 1'b1;
        tick();

        // Fill to capacity, refused fifth push, drain in order.
        for (int i = 0; i < 4; i++) begin
            set_push(32'h1000 + 32'(i) * 32'h10, 4'b0000);
            tick();
        end
        check("full_count", count_o, 4);
        check("full_ready", push_ready_o, 0);
        set_push(32'h1040, 4'b0000);
        tick();
        push_valid_i = 1'b0;
        pop_i = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        tick();  // pop while empty is ignored
        pop_i = 1'b0;

        // Steady occupancy of two with simultaneous push/pop across pointer wrap.
        set_push(32'h3000, 4'b0001);
        tick();
        set_push(32'h3010, 4'b0010);
        tick();
        pop_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            set_push(32'h3020 + 32'(i) * 32'h10, 4'(i));
            tick();
            check("wrap_count", count_o, 2);
        end
        push_valid_i = 1'b0;
        tick();
        tick();
        pop_i = 1'b0;

        // Snoop on a resident entry.
        set_push(32'h0000_5230, 4'b0000);
        tick();
        push_valid_i = 1'b0;
        snoop_taddr_i = 32'h230; snoop_twe_i = 4'b0010; snoop_tag_i = 20'h00005; snoop_wp_i = 1'b1;
        tick();
        check("snoop_wp1", head_hit_o, 4'b0010);
        snoop_wp_i = 1'b0;
        tick();
        check("snoop_wp0", head_hit_o, 4'b0000);
        snoop_wp_i = 1'b1;
        tick();
        snoop_taddr_i = 32'h240; snoop_wp_i = 1'b0;
        tick();
        check("snoop_other_set", head_hit_o, 4'b0010);
        snoop_twe_i = 4'b0000;
        pop_i = 1'b1;
        tick();
        pop_i = 1'b0;

        // Snoop colliding with the push of the same line.
        set_push(32'h0000_7110, 4'b0001);
        snoop_taddr_i = 32'h110; snoop_twe_i = 4'b0001; snoop_tag_i = 20'h00008; snoop_wp_i = 1'b1;
        tick();
        push_valid_i = 1'b0;
        snoop_twe_i = 4'b0000;
        check("push_snoop_hit", head_hit_o, 4'b0000);
        pop_i = 1'b1;
        tick();
        pop_i = 1'b0;

        // Load conflict query.
        set_push(32'h2004, 4'b0000);
        tick();
        q_paddr_i = 32'h2006;
        #1 check("conflict_same_word", q_conflict_o, ref_conflict(q_paddr_i));
        check("conflict_same_word_k", q_conflict_o, 1);
        set_push(32'h2008, 4'b0000);
        q_paddr_i = 32'h2008;
        #1 check("conflict_excl_push", q_conflict_o, 0);
        push_valid_i = 1'b0;
        pop_i = 1'b1;
        tick();
        pop_i = 1'b0;
        q_paddr_i = 32'h2006;
        #1 check("conflict_after_pop", q_conflict_o, 0);

        // Clear overriding push and pop.
        for (int i = 0; i < 3; i++) begin
            set_push(32'h4000 + 32'(i) * 32'h10, 4'b0100);
            tick();
        end
        clear_i = 1'b1;
        pop_i = 1'b1;
        set_push(32'h4100, 4'b0000);
        tick();
        check("clear_count", count_o, 0);
        clear_i = 1'b0;
        pop_i = 1'b0;

        // Asynchronous reset mid-stream, then operation from empty.
        set_push(32'h6000, 4'b1000);
        tick();
        set_push(32'h6010, 4'b0000);
        tick();
        push_valid_i = 1'b0;
        q_paddr_i = 32'h6000;
        rst_n = 1'b0;
        #1 check_reset_outputs("async_rst");
        sb.delete();
        #2 rst_n = 1'b1;
        set_push(32'h6020, 4'b0011);
        tick();
        push_valid_i = 1'b0;
        pop_i = 1'b1;
        tick();
        pop_i = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
